// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: instruction-in / immediate-out handshake bundle for imm_ext_pipe
interface imm_ext_pipe_if #(parameter int DATA_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instr;
  logic [DATA_W-1:0] out_imm;
  logic              out_ext_used;
  logic              prefix_pending;
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_ext_used, prefix_pending
  );
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_ext_used, prefix_pending
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: one-stage immediate generator with EXT-prefix extension and valid/ready handshake
module imm_ext_pipe #(
  parameter int DATA_W    = 16,
  parameter bit PREFIX_EN = 1
) (
  input logic          clk,
  input logic          rst_n,
  imm_ext_pipe_if.slave bus
);
  logic [15:0]       i;
  logic [10:0]       ext11;
  logic              accept, is_ext, cls00, branch, cmp, ucmp, use_pfx, sh;
  logic [DATA_W-1:0] val, imm;
  assign i           = bus.in_instr;
  assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign accept      = bus.in_valid && bus.in_ready;
  // decode the instruction class and extend the selected field, prefixed when a prefix applies
  always_comb begin
    is_ext  = PREFIX_EN && i[15:11] == 5'b10111;
    cls00   = i[15:14] == 2'b00;
    branch  = i[15:14] == 2'b10 && i[13:11] <= 3'b100;
    cmp     = i[15:11] == 5'b10101;
    ucmp    = i[15:11] == 5'b10110;
    use_pfx = bus.prefix_pending && (cls00 || branch || cmp || ucmp);
    sh      = (cls00 && !i[13]) || branch;
    val     = cls00  ? (use_pfx ? DATA_W'($signed({ext11, i[5:0]}))  : DATA_W'($signed(i[5:0]))) :
              branch ? (use_pfx ? DATA_W'($signed({ext11, i[10:0]})) : DATA_W'($signed(i[10:0]))) :
              cmp    ? (use_pfx ? DATA_W'($signed({ext11, i[6:0]}))  : DATA_W'($signed(i[6:0]))) :
              ucmp   ? (use_pfx ? DATA_W'({ext11, i[6:0]})           : DATA_W'(i[6:0])) :
              i[15:14] == 2'b11 ? DATA_W'(i[4:1]) : '0;
    imm     = sh ? val << 1 : val;
  end
  // output register and prefix latch; EXT only arms the prefix, everything else loads a result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_instr      <= '0;
      bus.out_imm        <= '0;
      bus.out_ext_used   <= 1'b0;
      bus.prefix_pending <= 1'b0;
      ext11              <= '0;
    end else if (bus.flush) begin
      bus.out_valid      <= 1'b0;
      bus.prefix_pending <= 1'b0;
    end else if (accept && is_ext) begin
      ext11              <= i[10:0];
      bus.prefix_pending <= 1'b1;
      bus.out_valid      <= 1'b0;
    end else if (accept) begin
      bus.out_valid      <= 1'b1;
      bus.out_instr      <= i;
      bus.out_imm        <= imm;
      bus.out_ext_used   <= use_pfx;
      bus.prefix_pending <= 1'b0;
    end else begin
      bus.out_valid      <= bus.out_valid && !bus.out_ready;
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: table vectors, corner sequences and a per-DUT scoreboard over three configurations
module tb_imm_ext_pipe;
  logic        clk = 0, rst_n = 1, in_valid = 0, flush = 0, out_ready = 1;
  logic [15:0] in_instr = 0;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;

  imm_ext_pipe_if #(.DATA_W(16)) b16();
  imm_ext_pipe_if #(.DATA_W(32)) b32();
  imm_ext_pipe_if #(.DATA_W(16)) bn();
  assign b16.in_valid = in_valid;  assign b16.in_instr = in_instr;
  assign b16.flush    = flush;     assign b16.out_ready = out_ready;
  assign b32.in_valid = in_valid;  assign b32.in_instr = in_instr;
  assign b32.flush    = flush;     assign b32.out_ready = out_ready;
  assign bn.in_valid  = in_valid;  assign bn.in_instr  = in_instr;
  assign bn.flush     = flush;     assign bn.out_ready  = out_ready;

  imm_ext_pipe #(.DATA_W(16), .PREFIX_EN(1)) d16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  imm_ext_pipe #(.DATA_W(32), .PREFIX_EN(1)) d32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_ext_pipe #(.DATA_W(16), .PREFIX_EN(0)) dn  (.clk(clk), .rst_n(rst_n), .bus(bn.slave));

  typedef struct { logic [15:0] instr; logic [63:0] imm; logic used; } exp_t;
  typedef struct { logic [15:0] instr; logic [31:0] e16; logic [31:0] e32; } vec_t;
  exp_t        q[3][$];
  logic        pend[3];
  logic [10:0] e11[3];
  vec_t        tbl[11];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // reference immediate: returns {ext_used, imm masked to dw}
  function automatic logic [64:0] model(logic [15:0] i, logic p, logic [10:0] e, int dw, bit pen);
    int fw = 0, w;
    bit sg = 0, sh = 0, use_p = 0;
    logic [63:0] raw = 0;
    if (i[15:14] == 2'b00) begin fw = 6; sg = 1; sh = !i[13]; use_p = 1; end
    else if (i[15:14] == 2'b10) begin
      if (i[13:11] <= 3'd4) begin fw = 11; sg = 1; sh = 1; use_p = 1; end
      else if (i[13:11] == 3'd5) begin fw = 7; sg = 1; use_p = 1; end
      else if (i[13:11] == 3'd6) begin fw = 7; use_p = 1; end
    end else if (i[15:14] == 2'b11) raw = {60'b0, i[4:1]};
    if (fw > 0) raw = {48'b0, i} & ((64'd1 << fw) - 1);
    w = fw;
    if (p && use_p) begin raw = raw | ({53'b0, e} << fw); w = fw + 11; end
    if (sg && w > 0 && raw[w-1]) raw = raw | ~((64'd1 << w) - 1);
    if (sh) raw = raw << 1;
    if (dw < 64) raw = raw & ((64'd1 << dw) - 1);
    return {p && use_p && pen, raw};
  endfunction

  function automatic void mon(int id, int dw, bit pen, logic ir, logic ov, logic pp,
                              logic [15:0] oi, logic [63:0] om, logic ou);
    logic rdy;
    logic [64:0] m;
    exp_t x;
    rdy = !flush && (q[id].size() == 0 || out_ready);
    chk($sformatf("in_ready[%0d]", id), 64'(ir), 64'(rdy));
    chk($sformatf("out_valid[%0d]", id), 64'(ov), 64'(q[id].size() != 0));
    chk($sformatf("prefix_pending[%0d]", id), 64'(pp), 64'(pend[id]));
    if (q[id].size() != 0 && out_ready) begin
      x = q[id].pop_front();
      chk($sformatf("sb_instr[%0d]", id), 64'(oi), 64'(x.instr));
      chk($sformatf("sb_imm[%0d]", id), om, x.imm);
      chk($sformatf("sb_ext_used[%0d]", id), 64'(ou), 64'(x.used));
    end
    if (flush) begin
      q[id].delete();
      pend[id] = 0;
    end else if (in_valid && rdy) begin
      if (pen && in_instr[15:11] == 5'b10111) begin
        pend[id] = 1;
        e11[id]  = in_instr[10:0];
      end else begin
        m = model(in_instr, pend[id], e11[id], dw, pen);
        q[id].push_back('{in_instr, m[63:0], m[64]});
        pend[id] = 0;
      end
    end
  endfunction

  always @(negedge clk)
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin q[k].delete(); pend[k] = 0; e11[k] = 0; end
    end else begin
      mon(0, 16, 1, b16.in_ready, b16.out_valid, b16.prefix_pending, b16.out_instr, 64'(b16.out_imm), b16.out_ext_used);
      mon(1, 32, 1, b32.in_ready, b32.out_valid, b32.prefix_pending, b32.out_instr, 64'(b32.out_imm), b32.out_ext_used);
      mon(2, 16, 0, bn.in_ready,  bn.out_valid,  bn.prefix_pending,  bn.out_instr,  64'(bn.out_imm),  bn.out_ext_used);
    end

  task automatic step(logic v, logic [15:0] ins, logic ordy, logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
  endtask

  initial begin
    tbl[0]  = '{16'h003E, 32'h0000FFFC, 32'hFFFFFFFC};
    tbl[1]  = '{16'h101F, 32'h0000003E, 32'h0000003E};
    tbl[2]  = '{16'h2005, 32'h00000005, 32'h00000005};
    tbl[3]  = '{16'h3020, 32'h0000FFE0, 32'hFFFFFFE0};
    tbl[4]  = '{16'h8400, 32'h0000F800, 32'hFFFFF800};
    tbl[5]  = '{16'hA3FF, 32'h000007FE, 32'h000007FE};
    tbl[6]  = '{16'hA840, 32'h0000FFC0, 32'hFFFFFFC0};
    tbl[7]  = '{16'hB07F, 32'h0000007F, 32'h0000007F};
    tbl[8]  = '{16'hC01E, 32'h0000000F, 32'h0000000F};
    tbl[9]  = '{16'h4123, 32'h00000000, 32'h00000000};
    tbl[10] = '{16'h0020, 32'h0000FFC0, 32'hFFFFFFC0};
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", 64'(b32.out_valid), 0);
    chk("rst_prefix", 64'(b32.prefix_pending), 0);
    chk("rst_imm", 64'(b32.out_imm), 0);
    chk("rst_instr", 64'(b32.out_instr), 0);
    chk("rst_ext_used", 64'(b32.out_ext_used), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    for (int n = 0; n < 11; n++) begin
      step(1, tbl[n].instr, 1, 0);
      step(0, 16'h0, 1, 0);
      @(negedge clk);
      chk($sformatf("tbl16[%0d]", n), 64'(b16.out_imm), 64'(tbl[n].e16));
      chk($sformatf("tbl32[%0d]", n), 64'(b32.out_imm), 64'(tbl[n].e32));
      chk($sformatf("tbln[%0d]", n), 64'(bn.out_imm), 64'(tbl[n].e16));
      chk($sformatf("tbl_valid[%0d]", n), 64'(b32.out_valid), 1);
      chk($sformatf("tbl_ext[%0d]", n), 64'(b32.out_ext_used), 0);
    end

    step(1, 16'hB801, 1, 0);
    step(1, 16'h2005, 1, 0);
    @(negedge clk);
    chk("pfx_pending_set", 64'(b32.prefix_pending), 1);
    chk("pfx_no_output", 64'(b32.out_valid), 0);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("pfx_addi_imm32", 64'(b32.out_imm), 64'h45);
    chk("pfx_addi_imm16", 64'(b16.out_imm), 64'h45);
    chk("pfx_addi_used", 64'(b32.out_ext_used), 1);
    chk("pfx_addi_pending", 64'(b32.prefix_pending), 0);
    chk("pfx_ext_passthru", 64'(bn.out_ext_used), 0);

    step(1, 16'hB9FF, 1, 0);
    step(1, 16'h87FF, 1, 0);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("pfx_branch_imm32", 64'(b32.out_imm), 64'h001FFFFE);
    chk("pfx_branch_imm16", 64'(b16.out_imm), 64'hFFFE);

    step(1, 16'hBFFF, 1, 0);
    step(1, 16'hB801, 1, 0);
    step(1, 16'h2005, 1, 0);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("last_pfx_wins", 64'(b32.out_imm), 64'h45);

    step(1, 16'hB801, 1, 0);
    step(1, 16'h4123, 1, 0);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("discard_imm", 64'(b32.out_imm), 0);
    chk("discard_used", 64'(b32.out_ext_used), 0);
    chk("discard_pending", 64'(b32.prefix_pending), 0);

    step(1, 16'hB801, 1, 0);
    step(1, 16'h4123, 1, 1);
    @(negedge clk);
    chk("flush_in_ready", 64'(b32.in_ready), 0);
    step(1, 16'h2005, 1, 0);
    @(negedge clk);
    chk("flush_pending", 64'(b32.prefix_pending), 0);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("flush_imm", 64'(b32.out_imm), 5);
    chk("flush_used", 64'(b32.out_ext_used), 0);

    step(1, 16'h003E, 0, 0);
    step(1, 16'h2005, 0, 0);
    repeat (5) begin
      step(1, 16'h2005, 0, 0);
      @(negedge clk);
      chk("bp_in_ready", 64'(b32.in_ready), 0);
      chk("bp_valid", 64'(b32.out_valid), 1);
      chk("bp_imm", 64'(b32.out_imm), 64'hFFFFFFFC);
      chk("bp_instr", 64'(b32.out_instr), 64'h003E);
    end
    step(1, 16'h2005, 1, 0);
    @(negedge clk);
    chk("bp_release_ready", 64'(b32.in_ready), 1);
    step(1, 16'h101F, 1, 0);
    @(negedge clk);
    chk("b2b_1_valid", 64'(b32.out_valid), 1);
    chk("b2b_1_instr", 64'(b32.out_instr), 64'h2005);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("b2b_2_valid", 64'(b32.out_valid), 1);
    chk("b2b_2_instr", 64'(b32.out_instr), 64'h101F);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("b2b_drain", 64'(b32.out_valid), 0);

    step(1, 16'hB801, 0, 0);
    step(0, 16'h0, 0, 0);
    #2;
    chk("pre_rst_pending", 64'(b32.prefix_pending), 1);
    chk("pre_rst_valid", 64'(bn.out_valid), 1);
    rst_n = 0;
    #1;
    chk("async_pending", 64'(b32.prefix_pending), 0);
    chk("async_valid", 64'(bn.out_valid), 0);
    chk("async_instr", 64'(bn.out_instr), 0);
    chk("async_imm32", 64'(b32.out_imm), 0);
    chk("async_instr16", 64'(b16.out_instr), 0);
    @(posedge clk);
    #1 rst_n = 1;
    step(1, 16'h003E, 1, 0);
    step(0, 16'h0, 1, 0);
    @(negedge clk);
    chk("resume_valid", 64'(b16.out_valid), 1);
    chk("resume_imm16", 64'(b16.out_imm), 64'hFFFC);
    chk("resume_imm32", 64'(b32.out_imm), 64'hFFFFFFFC);
    repeat (2) step(0, 16'h0, 1, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
